// File: rtl/rf_writeback_ctrl.sv
// rtl/rf_writeback_ctrl.sv - RV32I register file write-port arbiter with load FIFO and pending scoreboard
// Optional WB_BYPASS_EN: forwards the in-flight write to rs1/rs2 and masks their hazard terms.
module rf_writeback_ctrl #(
  parameter int XLEN       = 32,
  parameter int REG_NUM    = 32,
  parameter int FIFO_DEPTH = 4,
  localparam int AW        = $clog2(REG_NUM)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [AW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic            hazard,
  output logic            rd_busy,
  output logic            rf_write,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            byp1_valid,
  output logic [XLEN-1:0] byp1_data,
  output logic            byp2_valid,
  output logic [XLEN-1:0] byp2_data
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0]    fifo_data [FIFO_DEPTH];
  logic [AW-1:0]      fifo_rd   [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;
  logic [REG_NUM-1:0] pending, pending_nxt;
  logic               full, empty, alu_wr, push, pop;

  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign mem_ready = !full;
  assign alu_wr    = alu_valid && (alu_rd != '0);
  // Loads to x0 still complete the handshake but never occupy a slot.
  assign push      = mem_valid && !full && (mem_rd != '0);
  assign pop       = !alu_wr && !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= mem_data;
      fifo_rd[wr_ptr]   <= mem_rd;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rf_write <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (alu_wr) begin
        rf_write <= 1'b1;
        rf_waddr <= alu_rd;
        rf_wdata <= alu_data;
      end else if (pop) begin
        rf_write <= 1'b1;
        rf_waddr <= fifo_rd[rd_ptr];
        rf_wdata <= fifo_data[rd_ptr];
      end else begin
        rf_write <= 1'b0;
      end
    end
  end

  // Clear first so a same-cycle reissue of the retiring register stays pending.
  always_comb begin
    pending_nxt = pending;
    if (rf_write && rf_waddr != '0) pending_nxt[rf_waddr] = 1'b0;
    if (issue_valid && issue_rd != '0) pending_nxt[issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pending <= '0;
    else          pending <= pending_nxt;
  end

`ifdef WB_BYPASS_EN
  assign byp1_valid = rf_write && (rf_waddr == rs1) && (rs1 != '0);
  assign byp1_data  = rf_wdata;
  assign byp2_valid = rf_write && (rf_waddr == rs2) && (rs2 != '0);
  assign byp2_data  = rf_wdata;
`else
  assign byp1_valid = 1'b0;
  assign byp1_data  = '0;
  assign byp2_valid = 1'b0;
  assign byp2_data  = '0;
`endif

  assign rd_busy = pending[issue_rd];
  assign hazard  = (pending[rs1] & ~byp1_valid) | (pending[rs2] & ~byp2_valid)
                 | (issue_valid & pending[issue_rd]);

endmodule
